// File: rtl/addc1_stream_adapter.sv
// rtl/addc1_stream_adapter.sv - credit-based ready/valid adapter around the add-constant-1 core; optional err checker under ADDC1_STREAM_ERR_EN
module addc1_stream_adapter #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             add_ce,
    output logic [WIDTH-1:0] add_a,
    input  logic             add_valid,
    input  logic [WIDTH-1:0] add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic               primed;
    logic [LATENCY-1:0] tag;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      fcnt;
    logic               in_fire;
    logic               out_fire;
    logic               wr_en;
    logic               fifo_full;
    logic               wr_ok;

    // occ counts buffered plus in-flight results, so an accept always owns a slot
    assign in_ready  = primed && (occ < DEPTH_C);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (fcnt != '0);
    assign out_fire  = out_valid && out_ready;
    assign add_a     = in_data;
    assign out_data  = mem[rd_ptr];
    assign wr_en     = tag[LATENCY-1];
    assign fifo_full = (fcnt == DEPTH_C);
    // A write into a full FIFO is only harmless if the head is leaving the same edge
    assign wr_ok     = wr_en && (!fifo_full || out_fire);

    // Core enable, priming latch, tag pipeline and credit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_ce <= 1'b0;
            primed <= 1'b0;
            tag    <= '0;
            occ    <= '0;
        end else begin
            add_ce <= 1'b1;
            if (add_valid) begin
                primed <= 1'b1;
            end
            tag[0] <= in_fire;
            for (int i = 1; i < LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            occ <= occ + CW'(in_fire) - CW'(out_fire);
        end
    end

    // Result FIFO: capture add_s when the matching tag exits, first-word fall-through read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= add_s;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (out_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fcnt <= fcnt + CW'(wr_ok) - CW'(out_fire);
        end
    end

`ifdef ADDC1_STREAM_ERR_EN
    // Sticky error: a result came due while the core was unprimed, or the FIFO overflowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((wr_en && !add_valid) || (wr_en && fifo_full && !out_fire)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_addc1_stream_adapter.sv
// tb/tb_addc1_stream_adapter.sv - scoreboard bench for addc1_stream_adapter with an FP16 add-one core model
module tb_addc1_stream_adapter;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
`ifdef ADDC1_STREAM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             add_ce;
    logic [WIDTH-1:0] add_a;
    logic             add_valid;
    logic [WIDTH-1:0] add_s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             err;

    addc1_stream_adapter #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_ce(add_ce), .add_a(add_a), .add_valid(add_valid), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // FP16 x + 1.0 for the operand set the bench draws from
    function automatic logic [15:0] core_fn(input logic [15:0] x);
        case (x)
            16'h0000: return 16'h3C00;
            16'h3C00: return 16'h4000;
            16'h4000: return 16'h4200;
            16'hBC00: return 16'h0000;
            16'h4200: return 16'h4400;
            16'h4400: return 16'h4500;
            16'h4500: return 16'h4600;
            16'hC000: return 16'hBC00;
            16'h3800: return 16'h3E00;
            16'hB800: return 16'h3800;
            default:  return 16'hDEAD;
        endcase
    endfunction

    logic [15:0] tbl [10] = '{16'h0000, 16'h3C00, 16'h4000, 16'hBC00, 16'h4200,
                               16'h4400, 16'h4500, 16'hC000, 16'h3800, 16'hB800};

    // Core wrapper model: LATENCY-deep pipeline, primed two enabled cycles after start
    logic [15:0] stg [LATENCY];
    int          ce_cnt;
    logic        av_q;
    logic        kill;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
            ce_cnt <= 0;
            av_q   <= 1'b0;
        end else if (add_ce) begin
            stg[0] <= core_fn(add_a);
            for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
            ce_cnt <= ce_cnt + 1;
            if (ce_cnt + 1 >= 2) av_q <= 1'b1;
        end
    end

    assign add_s     = stg[LATENCY-1];
    assign add_valid = av_q && !kill;

    // Scoreboard state
    logic [15:0] exp_q [$];
    int          acc_q [$];
    int          acc_count = 0;
    int          pop_count = 0;
    int          first_acc = -1;
    int          first_pop = -1;
    logic [15:0] last_pop_data = '0;
    bit          log_en = 1'b0;
    logic [15:0] log_data [$];
    int          log_cyc [$];

    // Monitor: handshakes seen at negedge complete on the following posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(core_fn(in_data));
                acc_q.push_back(cyc + 1);
                acc_count++;
                if (first_acc < 0) first_acc = cyc + 1;
            end
            if (out_valid && out_ready) begin
                pop_count++;
                last_pop_data = out_data;
                if (first_pop < 0) first_pop = cyc + 1;
                if (log_en) begin
                    log_data.push_back(out_data);
                    log_cyc.push_back(cyc + 1);
                end
                chk("result_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("result_data", out_data, exp_q.pop_front());
                    chk("min_latency", (cyc + 1 - acc_q.pop_front()) >= LATENCY + 1, 1'b1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input string name, input int target);
        int n = 0;
        while (acc_count < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, acc_count >= target, 1'b1);
    endtask

    task automatic wait_pop(input string name, input int target);
        int n = 0;
        while (pop_count < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, pop_count >= target, 1'b1);
    endtask

    logic [15:0] stream_in  [4] = '{16'h0000, 16'h3C00, 16'h4000, 16'hBC00};
    logic [15:0] stream_out [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000};

    initial begin
        int rel_cyc;
        int base_a;
        int base_p;
        int pop_idx;
        int acc_idx;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; kill = 1'b0;
        repeat (3) tick();
        chk("reset_add_ce", add_ce, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("reset_err", err, 1'b0);

        // Priming: operand held from release, accept only once primed
        in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b1;
        rel_cyc = cyc;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("in_ready_before_primed", in_ready, 1'b0);
        end
        wait_acc("prime_accept_timeout", 1);
        tick();
        in_valid = 1'b0;
        chk("first_accept_edge", first_acc - rel_cyc, 5);
        wait_pop("prime_result_timeout", 1);
        chk("first_result_latency", first_pop - first_acc, LATENCY + 1);
        chk("first_result_data", last_pop_data, 16'h4000);

        // Streaming: four back-to-back operands, results with no bubbles
        repeat (2) tick();
        log_en = 1'b1;
        base_a = acc_count;
        base_p = pop_count;
        for (int i = 0; i < 4; i++) begin
            in_data = stream_in[i];
            in_valid = 1'b1;
            wait_acc("stream_accept_timeout", base_a + i + 1);
            tick();
        end
        in_valid = 1'b0;
        wait_pop("stream_result_timeout", base_p + 4);
        log_en = 1'b0;
        chk("stream_count", log_data.size(), 4);
        if (log_data.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("stream_value", log_data[i], stream_out[i]);
            chk("stream_no_bubbles", log_cyc[3] - log_cyc[0], 3);
        end

        // Backpressure: exactly DEPTH accepts, then accept one cycle after first pop
        repeat (2) tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        base_a = acc_count;
        for (int i = 0; i < 12; i++) begin
            in_data = tbl[$urandom_range(9, 0)];
            tick();
        end
        chk("bp_accept_count", acc_count - base_a, DEPTH);
        chk("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        base_a = acc_count;
        base_p = pop_count;
        pop_idx = -1;
        acc_idx = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (pop_idx < 0 && pop_count != base_p) pop_idx = i;
            if (acc_idx < 0 && acc_count != base_a) acc_idx = i;
        end
        chk("bp_accept_after_pop", acc_idx - pop_idx, 1);
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        chk("bp_drained", exp_q.size(), 0);

        // Simultaneous pop and accept at full occupancy
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = tbl[$urandom_range(9, 0)];
            tick();
        end
        base_a = acc_count;
        base_p = pop_count;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        chk("full_pulse_pops", pop_count - base_p, 1);
        chk("full_pulse_accepts", acc_count - base_a, 1);
        chk("full_pulse_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("full_drained", exp_q.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(99, 0) < 60);
            in_data   = tbl[$urandom_range(9, 0)];
            out_ready = ($urandom_range(99, 0) < 70);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("random_drained", exp_q.size(), 0);
        chk("random_err_clear", err, 1'b0);

        // Reset with two results buffered and two in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        base_a = acc_count;
        for (int i = 0; i < 4; i++) begin
            in_data = tbl[$urandom_range(9, 0)];
            wait_acc("midrst_accept_timeout", base_a + i + 1);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 16'h0000);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_add_ce", add_ce, 1'b0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        base_p = pop_count;
        repeat (20) tick();
        chk("midrst_no_stale", pop_count - base_p, 0);
        in_data = 16'h4200;
        in_valid = 1'b1;
        wait_acc("post_rst_accept_timeout", acc_count + 1);
        tick();
        in_valid = 1'b0;
        wait_pop("post_rst_result_timeout", base_p + 1);
        chk("post_rst_data", last_pop_data, 16'h4400);

        // Core loses priming while a tag exits
        repeat (3) tick();
        chk("err_before", err, 1'b0);
        in_data = 16'h3800;
        in_valid = 1'b1;
        wait_acc("err_accept_timeout", acc_count + 1);
        tick();
        in_valid = 1'b0;
        kill = 1'b1;
        repeat (LATENCY + 1) tick();
        kill = 1'b0;
        chk("err_set", err, ERR_ON);
        repeat (5) tick();
        chk("err_sticky", err, ERR_ON);
        chk("err_drained", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        chk("err_cleared_by_rst", err, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
